// File: rtl/aes_control_multi.sv
// Round sequencer for an iterative AES datapath.
// Handles 10/12/14-round blocks, encrypt/decrypt key ordering, CPR clocks per
// round, a ready handshake with back-to-back acceptance, and sticky
// collision / configuration-error interrupts with a saturating drop counter.
module aes_control_multi #(
  parameter int CPR     = 3,
  parameter int PHASE_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               kill,
  input  logic               in_en,
  input  logic [1:0]         key_len,
  input  logic               decrypt,
  input  logic               irq_clr,
  output logic               in_ready,
  output logic               start,
  output logic               key_ready,
  output logic [3:0]         key_idx,
  output logic [3:0]         round_idx,
  output logic [PHASE_W-1:0] phase,
  output logic               en_mixcol,
  output logic               out_en,
  output logic               busy,
  output logic               collision_irq,
  output logic               cfg_err_irq,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CPR - 1);
  localparam logic [CNT_W-1:0]   DROP_MAX   = '1;

  state_t             state_reg, state_next;
  logic [3:0]         nr_reg, nr_next;
  logic               dec_reg, dec_next;
  logic [3:0]         round_reg, round_next;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic               coll_irq_reg, coll_irq_next;
  logic               cfg_irq_reg, cfg_irq_next;
  logic [CNT_W-1:0]   drop_reg, drop_next;

  logic               accept;
  logic               coll_set;
  logic               cfg_set;
  logic [3:0]         nr_sel;

  // Request classification: a request is either accepted, rejected for a
  // reserved key length, or rejected because a block is in flight.
  always_comb begin
    in_ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
    accept   = in_en && in_ready && (key_len != 2'b11);
    cfg_set  = in_en && in_ready && (key_len == 2'b11);
    coll_set = in_en && !in_ready;
    case (key_len)
      2'b01:   nr_sel = 4'd12;
      2'b10:   nr_sel = 4'd14;
      default: nr_sel = 4'd10;
    endcase
  end

  // State, round/phase counters, interrupts and drop counter; kill wins.
  always_ff @(posedge clk) begin
    if (kill) begin
      state_reg    <= S_IDLE;
      nr_reg       <= 4'd10;
      dec_reg      <= 1'b0;
      round_reg    <= '0;
      phase_reg    <= '0;
      coll_irq_reg <= 1'b0;
      cfg_irq_reg  <= 1'b0;
      drop_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      nr_reg       <= nr_next;
      dec_reg      <= dec_next;
      round_reg    <= round_next;
      phase_reg    <= phase_next;
      coll_irq_reg <= coll_irq_next;
      cfg_irq_reg  <= cfg_irq_next;
      drop_reg     <= drop_next;
    end
  end

  // Next-state logic: the phase counter wraps at CPR-1, then the round advances
  // until the final round's last phase hands over to DONE.
  always_comb begin
    state_next = state_reg;
    nr_next    = nr_reg;
    dec_next   = dec_reg;
    round_next = round_reg;
    phase_next = phase_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        round_next = '0;
        phase_next = '0;
        if (accept) begin
          nr_next    = nr_sel;
          dec_next   = decrypt;
          state_next = S_LOAD;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        state_next = S_ROUND;
        round_next = 4'd1;
        phase_next = '0;
      end
      S_ROUND: begin
        if (phase_reg == PHASE_LAST) begin
          phase_next = '0;
          if (round_reg == nr_reg) begin
            state_next = S_DONE;
          end else begin
            round_next = round_reg + 4'd1;
          end
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sticky interrupts: a set event beats a coincident clear, and the drop
  // counter then restarts at 1 rather than 0.
  always_comb begin
    coll_irq_next = coll_set || (coll_irq_reg && !irq_clr);
    cfg_irq_next  = cfg_set  || (cfg_irq_reg  && !irq_clr);
    drop_next     = drop_reg;
    if (coll_set || cfg_set) begin
      if (irq_clr) begin
        drop_next = CNT_W'(1);
      end else if (drop_reg != DROP_MAX) begin
        drop_next = drop_reg + CNT_W'(1);
      end
    end else if (irq_clr) begin
      drop_next = '0;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    start     = 1'b0;
    key_ready = 1'b0;
    key_idx   = '0;
    round_idx = '0;
    phase     = '0;
    en_mixcol = 1'b0;
    out_en    = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      S_LOAD: begin
        start     = 1'b1;
        key_ready = 1'b1;
        busy      = 1'b1;
        key_idx   = dec_reg ? nr_reg : 4'd0;
      end
      S_ROUND: begin
        busy      = 1'b1;
        round_idx = round_reg;
        phase     = phase_reg;
        en_mixcol = (round_reg == nr_reg);
        if (phase_reg == '0) begin
          key_ready = 1'b1;
          key_idx   = dec_reg ? (nr_reg - round_reg) : round_reg;
        end
      end
      S_DONE:  out_en = 1'b1;
      default: ;
    endcase
  end

  assign collision_irq = coll_irq_reg;
  assign cfg_err_irq   = cfg_irq_reg;
  assign drop_cnt      = drop_reg;

endmodule

// File: tb/tb_aes_control_multi.sv
// Directed bench for aes_control_multi: three instances (CPR=3, CPR=2,
// CNT_W=2) share one stimulus; sel chooses which instance is checked.
module tb_aes_control_multi;

  logic       clk = 1'b0;
  logic       kill = 1'b1;
  logic       in_en = 1'b0;
  logic [1:0] key_len = 2'b00;
  logic       decrypt = 1'b0;
  logic       irq_clr = 1'b0;

  logic       rdy_v[3], start_v[3], kr_v[3], mix_v[3], oe_v[3], busy_v[3], coll_v[3], cfg_v[3];
  logic [3:0] kidx_v[3], ridx_v[3];
  logic [2:0] ph_v[3];
  logic [7:0] drop_v[3];
  logic [7:0] drop1;
  logic [1:0] drop2;

  int sel = 0;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int oe_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_control_multi #(.CPR(3), .PHASE_W(3), .CNT_W(8)) u_dut (
    .clk(clk), .kill(kill), .in_en(in_en), .key_len(key_len), .decrypt(decrypt), .irq_clr(irq_clr),
    .in_ready(rdy_v[0]), .start(start_v[0]), .key_ready(kr_v[0]), .key_idx(kidx_v[0]),
    .round_idx(ridx_v[0]), .phase(ph_v[0]), .en_mixcol(mix_v[0]), .out_en(oe_v[0]), .busy(busy_v[0]),
    .collision_irq(coll_v[0]), .cfg_err_irq(cfg_v[0]), .drop_cnt(drop_v[0]));

  aes_control_multi #(.CPR(2), .PHASE_W(3), .CNT_W(8)) u_cpr2 (
    .clk(clk), .kill(kill), .in_en(in_en), .key_len(key_len), .decrypt(decrypt), .irq_clr(irq_clr),
    .in_ready(rdy_v[1]), .start(start_v[1]), .key_ready(kr_v[1]), .key_idx(kidx_v[1]),
    .round_idx(ridx_v[1]), .phase(ph_v[1]), .en_mixcol(mix_v[1]), .out_en(oe_v[1]), .busy(busy_v[1]),
    .collision_irq(coll_v[1]), .cfg_err_irq(cfg_v[1]), .drop_cnt(drop1));

  aes_control_multi #(.CPR(3), .PHASE_W(3), .CNT_W(2)) u_cnt2 (
    .clk(clk), .kill(kill), .in_en(in_en), .key_len(key_len), .decrypt(decrypt), .irq_clr(irq_clr),
    .in_ready(rdy_v[2]), .start(start_v[2]), .key_ready(kr_v[2]), .key_idx(kidx_v[2]),
    .round_idx(ridx_v[2]), .phase(ph_v[2]), .en_mixcol(mix_v[2]), .out_en(oe_v[2]), .busy(busy_v[2]),
    .collision_irq(coll_v[2]), .cfg_err_irq(cfg_v[2]), .drop_cnt(drop2));

  assign drop_v[1] = drop1;
  assign drop_v[2] = {6'b0, drop2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d (sel=%0d cyc=%0d)", tag, obs, exp, sel, cyc);
    end
  endtask

  task automatic do_kill();
    kill = 1'b1;
    tick();
    tick();
    kill = 1'b0;
  endtask

  // Present one request; afterwards scramble key_len/decrypt to show they are ignored.
  task automatic accept(input logic [1:0] kl, input logic dec);
    key_len = kl;
    decrypt = dec;
    in_en   = 1'b1;
    tick();
    in_en   = 1'b0;
    key_len = ~kl;
    decrypt = ~dec;
  endtask

  task automatic idle_chk();
    chk("idle_in_ready", rdy_v[sel], 1);
    chk("idle_busy", busy_v[sel], 0);
    chk("idle_out_en", oe_v[sel], 0);
    chk("idle_start", start_v[sel], 0);
    chk("idle_round_idx", ridx_v[sel], 0);
  endtask

  // Walk one block from the LOAD cycle (k=1, i.e. T+1) through DONE (k=2+Nr*CPR).
  task automatic follow(input int nr, input int dec, input int cpr, input int exp_lat,
                        input int b2b, input logic [1:0] kl_next, input int coll, input int kill_k);
    int last;
    int r;
    int p;
    int oe_k;
    int nc;
    int exp_kr;
    last = 2 + nr * cpr;
    oe_k = -1;
    nc = 0;
    for (int k = 1; k <= last; k++) begin
      if (k >= 2 && k < last) begin
        r = (k - 2) / cpr + 1;
        p = (k - 2) % cpr;
      end else begin
        r = 0;
        p = 0;
      end
      exp_kr = ((k == 1) || (r != 0 && p == 0)) ? 1 : 0;
      chk("start", start_v[sel], (k == 1) ? 1 : 0);
      chk("busy", busy_v[sel], (k < last) ? 1 : 0);
      chk("out_en", oe_v[sel], (k == last) ? 1 : 0);
      chk("in_ready", rdy_v[sel], (k == last) ? 1 : 0);
      chk("key_ready", kr_v[sel], exp_kr);
      if (exp_kr == 1) begin
        if (k == 1) chk("key_idx_load", kidx_v[sel], (dec != 0) ? nr : 0);
        else        chk("key_idx", kidx_v[sel], (dec != 0) ? (nr - r) : r);
      end
      chk("round_idx", ridx_v[sel], r);
      chk("phase", ph_v[sel], p);
      chk("en_mixcol", mix_v[sel], (r == nr) ? 1 : 0);
      if (oe_v[sel] === 1'b1) begin
        oe_k = k;
        oe_cyc = cyc;
      end
      if (k == kill_k) begin
        kill = 1'b1;
        tick();
        kill = 1'b0;
        return;
      end
      if (coll != 0 && k >= 5 && (k % 5) == 0 && nc < 3) begin
        in_en = 1'b1;
        nc++;
      end
      if (b2b != 0 && k == last) begin
        in_en   = 1'b1;
        key_len = kl_next;
        decrypt = (dec != 0);
      end
      tick();
      in_en = 1'b0;
    end
    chk("latency", oe_k, exp_lat);
  endtask

  initial begin
    int n_oe;
    int oe_first;

    // Reset: outputs cleared, in_ready high, in_en ignored under kill.
    kill = 1'b1;
    tick();
    chk("rst_in_ready", rdy_v[0], 1);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_start", start_v[0], 0);
    chk("rst_out_en", oe_v[0], 0);
    chk("rst_key_ready", kr_v[0], 0);
    chk("rst_coll", coll_v[0], 0);
    chk("rst_cfg", cfg_v[0], 0);
    chk("rst_drop", drop_v[0], 0);
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    chk("kill_ignores_in_en", busy_v[0], 0);
    kill = 1'b0;
    tick();
    chk("post_kill_idle", busy_v[0], 0);

    // AES-128 encrypt, CPR=3: out_en at T+32.
    sel = 0;
    accept(2'b00, 1'b0);
    follow(10, 0, 3, 32, 0, 2'b00, 0, 0);
    idle_chk();
    chk("enc128_no_coll", coll_v[0], 0);

    // AES-256 decrypt, CPR=2: key_idx 14..0, out_en at T+30.
    do_kill();
    sel = 1;
    accept(2'b10, 1'b1);
    follow(14, 1, 2, 30, 0, 2'b00, 0, 0);
    idle_chk();

    // AES-192 back-to-back, CPR=3: 38 cycles between the two out_en pulses.
    do_kill();
    sel = 0;
    accept(2'b01, 1'b0);
    follow(12, 0, 3, 38, 1, 2'b01, 0, 0);
    oe_first = oe_cyc;
    follow(12, 0, 3, 38, 0, 2'b00, 0, 0);
    chk("b2b_gap", oe_cyc - oe_first, 38);
    chk("b2b_no_coll", coll_v[0], 0);
    chk("b2b_drop", drop_v[0], 0);
    idle_chk();

    // Three collisions during ROUND leave the sequence untouched.
    do_kill();
    accept(2'b00, 1'b0);
    follow(10, 0, 3, 32, 0, 2'b00, 1, 0);
    chk("coll_irq", coll_v[0], 1);
    chk("coll_drop", drop_v[0], 3);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("coll_irq_cleared", coll_v[0], 0);
    chk("coll_drop_cleared", drop_v[0], 0);

    // Reserved key length in IDLE.
    do_kill();
    key_len = 2'b11;
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    chk("cfg_no_start", start_v[0], 0);
    chk("cfg_busy", busy_v[0], 0);
    chk("cfg_irq", cfg_v[0], 1);
    chk("cfg_drop", drop_v[0], 1);
    chk("cfg_no_coll", coll_v[0], 0);
    tick();
    chk("cfg_still_idle", start_v[0], 0);

    // Saturation with CNT_W=2; the 8-bit instance keeps counting.
    do_kill();
    sel = 2;
    key_len = 2'b11;
    in_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    in_en = 1'b0;
    chk("sat_drop", drop_v[2], 3);
    chk("sat_cfg", cfg_v[2], 1);
    chk("nosat_drop", drop_v[0], 5);
    irq_clr = 1'b1;
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    chk("clr_set_drop", drop_v[2], 1);
    chk("clr_set_cfg", cfg_v[2], 1);
    tick();
    irq_clr = 1'b0;
    chk("clr_drop", drop_v[2], 0);
    chk("clr_cfg", cfg_v[2], 0);

    // Kill at round 5 phase 1, then a normal block.
    do_kill();
    sel = 0;
    accept(2'b00, 1'b0);
    follow(10, 0, 3, 32, 0, 2'b00, 0, 15);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_round_idx", ridx_v[0], 0);
    chk("abort_phase", ph_v[0], 0);
    chk("abort_in_ready", rdy_v[0], 1);
    chk("abort_out_en", oe_v[0], 0);
    n_oe = 0;
    for (int i = 0; i < 50; i++) begin
      if (oe_v[0] === 1'b1) n_oe++;
      tick();
    end
    chk("abort_no_out_en", n_oe, 0);
    accept(2'b00, 1'b0);
    follow(10, 0, 3, 32, 0, 2'b00, 0, 0);
    idle_chk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_control_multi.md
Name: aes_control_multi

Overview:
- Parametrised round sequencer for the iterative AES datapath.
- Supports AES-128/192/256 key lengths (10/12/14 rounds) selected per block at run time.
- Supports encrypt/decrypt key-index ordering and a configurable number of clocks per round.
- Adds an explicit ready handshake with back-to-back acceptance, a sticky collision interrupt with a saturating drop counter, and a configuration-error flag.

Parameters:
- CPR, 3: clocks per round, legal range 1..8.
- PHASE_W, 3: width of the phase output; must satisfy 2^PHASE_W >= CPR.
- CNT_W, 8: width of the collision drop counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- kill  in  1  synchronous active-high reset.
- in_en  in  1  block request; accepted only when in_ready=1.
- key_len  in  2  sampled with an accepted in_en: 00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=reserved.
- decrypt  in  1  sampled with an accepted in_en; selects descending key index.
- irq_clr  in  1  clears collision_irq, cfg_err_irq and drop_cnt.
- in_ready  out  1  combinational: state is IDLE or DONE.
- start  out  1  one-cycle pulse in LOAD (datapath captures the block).
- key_ready  out  1  one-cycle pulse: LOAD cycle, and phase 0 of every round.
- key_idx  out  4  round-key index valid while key_ready=1.
- round_idx  out  4  current round 1..Nr; 0 outside ROUND.
- phase  out  PHASE_W  cycle within round, 0..CPR-1; 0 outside ROUND.
- en_mixcol  out  1  1 = bypass MixColumns; high for every cycle of round Nr.
- out_en  out  1  one-cycle result-valid pulse in DONE.
- busy  out  1  high in LOAD and ROUND.
- collision_irq  out  1  sticky: in_en seen while in_ready=0.
- cfg_err_irq  out  1  sticky: in_en with key_len=11 while in_ready=1.
- drop_cnt  out  CNT_W  saturating count of rejected requests (collisions plus cfg errors).

Behaviour:
- Reset: kill=1 forces state IDLE, nr=10, dec=0 and clears every registered output and irq/counter to 0. in_ready reads 1 from the first cycle after kill. in_en is ignored while kill=1.
- Single clock domain. Every output except in_ready is registered or decoded from registered state only.
- IDLE:
  - in_en=1 with key_len != 11: latch nr and dec, go to LOAD.
  - in_en=1 with key_len = 11: stay in IDLE, set cfg_err_irq, increment drop_cnt.
- LOAD (1 cycle):
  - start=1, key_ready=1, key_idx = dec ? nr : 0.
  - Next state is ROUND with round=1, phase=0.
- ROUND:
  - phase increments each cycle and wraps at CPR-1, after which round increments.
  - At phase 0: key_ready=1, key_idx = dec ? nr-round : round.
  - en_mixcol=1 when round==nr.
  - At round==nr and phase==CPR-1: next state is DONE.
  - CPR=1: phase is held at 0 and key_ready is high on every ROUND cycle.
- DONE (1 cycle):
  - out_en=1, busy=0, in_ready=1.
  - A valid in_en here goes directly to LOAD (back-to-back, no bubble). Otherwise the next state is IDLE.
- Latency: in_en accepted in cycle T → start at T+1 → out_en at T+2+Nr*CPR. Example: AES-128 with CPR=3 gives T+32.
- Minimum initiation interval for back-to-back blocks: 2+Nr*CPR cycles.
- Collision: in_en=1 with in_ready=0 (LOAD or ROUND) does not disturb the sequence. It sets collision_irq and increments drop_cnt.
- drop_cnt saturates at 2^CNT_W-1 and does not wrap.
- irq_clr in the same cycle as a new set event: set wins, and drop_cnt is reloaded to 1 instead of 0.
- key_len and decrypt are ignored except in the accepting cycle. Changing them mid-block has no effect.
- kill mid-block: the next cycle is IDLE with all outputs 0. No out_en is ever issued for the aborted block.

Test Plan:
- CPR=3, key_len=00, decrypt=0, single in_en at T → start at T+1; key_ready at T+1, T+2, T+5, …, T+29 with key_idx 0..10; en_mixcol high T+29..T+31; out_en only at T+32.
- CPR=2, key_len=10, decrypt=1 → key_idx sequence 14,13,…,0 over 15 key_ready pulses; out_en at T+30; round_idx 14 during T+28..T+29.
- CPR=3, AES-192, second in_en held high during the DONE cycle → second start exactly one cycle after out_en; no collision_irq; second out_en 38 cycles after the first.
- in_en pulsed 3 times during ROUND → sequence unchanged; collision_irq=1, drop_cnt=3; irq_clr with no coincident in_en → both return to 0 the next cycle.
- key_len=11 in IDLE → no start; cfg_err_irq=1, drop_cnt=1; with CNT_W=2, 5 rejected requests → drop_cnt holds 3.
- kill asserted at round 5 phase 1 → next cycle busy=0, round_idx=0, in_ready=1; no out_en within 50 cycles; a new in_en then completes normally.
